// File: rtl/dram_resp_pkg.sv
// Shared types and defaults for the DRAM responder model: command/state encodings,
// default timing parameters and the command decoder.
package dram_resp_pkg;

  localparam int unsigned DEF_ROW_BITS = 6;
  localparam int unsigned DEF_COL_BITS = 4;
  localparam int unsigned DEF_CAS_LAT  = 5;
  localparam int unsigned DEF_T_RCD    = 2;
  localparam int unsigned DEF_T_RP     = 2;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned BYTES  = DATA_W / 8;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_PRE,
    CMD_READ,
    CMD_WRITE
  } cmd_e;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  function automatic cmd_e decode_cmd(input logic csn, input logic rasn, input logic casn,
                                      input logic [BYTES-1:0] wen);
    cmd_e c;
    c = CMD_NOP;
    if (!csn) begin
      if (!rasn && casn) begin
        if (wen == '1)      c = CMD_ACT;
        else if (wen == '0) c = CMD_PRE;
      end else if (rasn && !casn) begin
        c = (wen == '1) ? CMD_READ : CMD_WRITE;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/dram_responder_if.sv
// Command/data bus between a DRAM controller (master) and the responder (slave).
interface dram_responder_if;
  import dram_resp_pkg::*;

  logic              CSn;
  logic              RASn;
  logic              CASn;
  logic [BYTES-1:0]  WEn;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;
  logic              VALID;

  modport master (output CSn, RASn, CASn, WEn, A, D, input Q, VALID);
  modport slave  (input CSn, RASn, CASn, WEn, A, D, output Q, VALID);
endinterface

// File: rtl/dram_resp_rdpipe.sv
// Fixed-depth valid/data shift pipeline for read returns; data is zero whenever
// the matching valid is low, so the output word is 0 outside a valid beat.
module dram_resp_rdpipe #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/dram_responder.sv
// Behavioural single-bank DRAM responder: ACT/PRE/READ/WRITE with CAS-latency reads.
// Optional tRCD/tRP and protocol checking with sticky err: DRAM_RESP_TIMING_CHK_EN.
module dram_responder
  import dram_resp_pkg::*;
#(
  parameter int unsigned ROW_BITS = DEF_ROW_BITS,
  parameter int unsigned COL_BITS = DEF_COL_BITS,
  parameter int unsigned CAS_LAT  = DEF_CAS_LAT,
  parameter int unsigned T_RCD    = DEF_T_RCD,
  parameter int unsigned T_RP     = DEF_T_RP
) (
  input  logic             clk,
  input  logic             rstn,
  dram_responder_if.slave  bus,
  output logic             err
);

  localparam int unsigned MEM_AW = ROW_BITS + COL_BITS;

  cmd_e                cmd;
  state_e              state;
  logic [ROW_BITS-1:0] open_row;
  logic [MEM_AW-1:0]   word_addr;
  logic                rcd_ok, rp_ok;
  logic                act_ok, rd_ok, wr_ok;

  logic [DATA_W-1:0]   mem [2**MEM_AW];
  logic                rd_vld_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                pipe_valid;
  logic [DATA_W-1:0]   pipe_data;

  always_comb begin
    cmd       = decode_cmd(bus.CSn, bus.RASn, bus.CASn, bus.WEn);
    word_addr = {open_row, bus.A[COL_BITS-1:0]};
    act_ok    = (cmd == CMD_ACT)   && (state == ST_IDLE)   && rp_ok;
    rd_ok     = (cmd == CMD_READ)  && (state == ST_ACTIVE) && rcd_ok;
    wr_ok     = (cmd == CMD_WRITE) && (state == ST_ACTIVE) && rcd_ok;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      open_row <= '0;
    end else if (cmd == CMD_PRE) begin
      state <= ST_IDLE;
    end else if (act_ok) begin
      state    <= ST_ACTIVE;
      open_row <= bus.A[ROW_BITS-1:0];
    end
  end

  // Storage is never reset. A READ and WRITE cannot share an edge, so the
  // captured word is always the pre-write contents of the addressed location.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (!bus.WEn[i]) mem[word_addr][8*i +: 8] <= bus.D[8*i +: 8];
      end
    end
    if (rd_ok) rd_data_q <= mem[word_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_vld_q <= 1'b0;
    else       rd_vld_q <= rd_ok;
  end

  // Capture register plus CAS_LAT pipe stages: VALID rises CAS_LAT edges after
  // the READ edge, since the capture edge itself is the READ edge.
  dram_resp_rdpipe #(
    .DEPTH (CAS_LAT),
    .W     (DATA_W)
  ) u_rdpipe (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (rd_vld_q),
    .in_data   (rd_data_q),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  assign bus.VALID = pipe_valid;
  assign bus.Q     = pipe_data;

`ifdef DRAM_RESP_TIMING_CHK_EN
  localparam int unsigned CNT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  logic [CNT_W-1:0] rcd_cnt, rp_cnt;
  logic             viol;

  always_comb begin
    rcd_ok = (rcd_cnt == '0);
    rp_ok  = (rp_cnt == '0);
    viol   = ((cmd == CMD_ACT)   && !act_ok) ||
             ((cmd == CMD_READ)  && !rd_ok)  ||
             ((cmd == CMD_WRITE) && !wr_ok);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rcd_cnt <= '0;
      rp_cnt  <= '0;
      err     <= 1'b0;
    end else begin
      if (act_ok)              rcd_cnt <= CNT_W'(T_RCD - 1);
      else if (rcd_cnt != '0)  rcd_cnt <= rcd_cnt - CNT_W'(1);
      if (cmd == CMD_PRE)      rp_cnt  <= CNT_W'(T_RP - 1);
      else if (rp_cnt != '0)   rp_cnt  <= rp_cnt - CNT_W'(1);
      if (viol)                err     <= 1'b1;
    end
  end
`else
  assign rcd_ok = 1'b1;
  assign rp_ok  = 1'b1;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: directed scenarios followed by random
// traffic against a cycle-indexed behavioural model of the bank.
module tb_dram_responder;
  import dram_resp_pkg::*;

  localparam int ROW_BITS = 6;
  localparam int COL_BITS = 4;
  localparam int CAS_LAT  = 5;
  localparam int T_RCD    = 2;
  localparam int T_RP     = 2;
`ifdef DRAM_RESP_TIMING_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic err;
  always #5 clk = ~clk;

  dram_responder_if bus ();

  dram_responder #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS),
    .CAS_LAT  (CAS_LAT),
    .T_RCD    (T_RCD),
    .T_RP     (T_RP)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .err  (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: bank contents by word index, open-row bookkeeping by cycle
  // number, and a list of read returns keyed by the cycle they are due.
  typedef struct { int due; bit [31:0] data; bit known; } rd_t;
  bit [31:0]   mdl_mem [int];
  rd_t         rdq [$];
  bit          mdl_open;
  int          mdl_row;
  int          last_act, last_pre;
  bit          mdl_err;
  int          cyc;
  logic [31:0] last_q;

  task automatic model_edge();
    bit act, pre, rd, wr, ok;
    int idx;
    bit [31:0] w;
    if (bus.CSn) return;
    act = !bus.RASn &&  bus.CASn && bus.WEn == 4'hF;
    pre = !bus.RASn &&  bus.CASn && bus.WEn == 4'h0;
    rd  =  bus.RASn && !bus.CASn && bus.WEn == 4'hF;
    wr  =  bus.RASn && !bus.CASn && bus.WEn != 4'hF;
    if (act) begin
      if (!mdl_open && (!CHK || cyc - last_pre >= T_RP)) begin
        mdl_open = 1'b1;
        mdl_row  = int'(bus.A) % (1 << ROW_BITS);
        last_act = cyc;
      end else if (CHK) mdl_err = 1'b1;
    end else if (pre) begin
      mdl_open = 1'b0;
      last_pre = cyc;
    end else if (rd || wr) begin
      ok  = mdl_open && (!CHK || cyc - last_act >= T_RCD);
      idx = mdl_row * (1 << COL_BITS) + int'(bus.A) % (1 << COL_BITS);
      if (!ok) begin
        if (CHK) mdl_err = 1'b1;
      end else if (rd) begin
        rdq.push_back('{cyc + CAS_LAT, mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0,
                        mdl_mem.exists(idx)});
      end else if (mdl_mem.exists(idx) || bus.WEn == 4'h0) begin
        w = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (!bus.WEn[b]) w[8*b +: 8] = bus.D[8*b +: 8];
        mdl_mem[idx] = w;
      end
    end
  endtask

  task automatic check_outputs();
    bit        exp_v = 1'b0;
    bit [31:0] exp_q = 32'h0;
    bit        known = 1'b1;
    if (rdq.size() != 0 && rdq[0].due == cyc) begin
      exp_v = 1'b1;
      exp_q = rdq[0].data;
      known = rdq[0].known;
      void'(rdq.pop_front());
    end
    check_eq("valid", 32'(bus.VALID), 32'(exp_v));
    if (!exp_v)     check_eq("q_idle", bus.Q, 32'h0);
    else if (known) check_eq("rdata", bus.Q, exp_q);
    check_eq("err", 32'(err), 32'(mdl_err));
    if (bus.VALID) last_q = bus.Q;
  endtask

  task automatic issue(input logic csn, input logic rasn, input logic casn,
                       input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    bus.CSn = csn; bus.RASn = rasn; bus.CASn = casn;
    bus.WEn = wen; bus.A = a; bus.D = d;
    @(posedge clk);
    cyc++;
    model_edge();
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic nop();
    issue(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 11'($urandom), $urandom);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  task automatic act(input int row);
    logic [10:0] a;
    a = 11'($urandom);
    a[ROW_BITS-1:0] = ROW_BITS'(row);
    issue(1'b0, 1'b0, 1'b1, 4'hF, a, $urandom);
  endtask

  task automatic pre();
    issue(1'b0, 1'b0, 1'b1, 4'h0, 11'($urandom), $urandom);
  endtask

  task automatic rd(input int col);
    logic [10:0] a;
    a = 11'($urandom);
    a[COL_BITS-1:0] = COL_BITS'(col);
    issue(1'b0, 1'b1, 1'b0, 4'hF, a, $urandom);
  endtask

  task automatic wr(input int col, input logic [31:0] d, input logic [3:0] wen);
    logic [10:0] a;
    a = 11'($urandom);
    a[COL_BITS-1:0] = COL_BITS'(col);
    issue(1'b0, 1'b1, 1'b0, wen, a, d);
  endtask

  task automatic do_reset();
    bus.CSn = 1'b1;
    rstn = 1'b0;
    #1;
    check_eq("rst_valid", 32'(bus.VALID), 32'h0);
    check_eq("rst_q", bus.Q, 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    rdq.delete();
    mdl_open = 1'b0;
    mdl_err  = 1'b0;
    last_act = -1000;
    last_pre = -1000;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int r;
    cyc = 0;
    last_q = 32'h0;
    bus.CSn = 1'b1; bus.RASn = 1'b1; bus.CASn = 1'b1;
    bus.WEn = 4'hF; bus.A = '0; bus.D = '0;
    do_reset();

    // ACT row 3, write then read col 5
    act(3); nop();
    wr(5, 32'hDEADBEEF, 4'h0);
    rd(5); nops(CAS_LAT + 1);
    check_eq("req020_q", last_q, 32'hDEADBEEF);

    // Byte-masked merge
    wr(6, 32'h11223344, 4'h0);
    wr(6, 32'hAABBCCDD, 4'b1010);
    rd(6); nops(CAS_LAT + 1);
    check_eq("req021_q", last_q, 32'h11BB33DD);

    // Back-to-back reads
    for (int c = 0; c < 4; c++) wr(c, 32'(c), 4'h0);
    nop();
    for (int c = 0; c < 4; c++) rd(c);
    nops(CAS_LAT + 2);
    check_eq("req022_last", last_q, 32'h3);

    // Write right behind an in-flight read of the same word
    wr(1, 32'h5, 4'h0);
    last_q = 32'h0;
    rd(1); wr(1, 32'h9, 4'h0); nops(CAS_LAT);
    check_eq("req023_old", last_q, 32'h5);
    rd(1); nops(CAS_LAT + 1);
    check_eq("req023_new", last_q, 32'h9);

    // Write one cycle after ACT
    pre(); nops(T_RP);
    act(2); nop();
    wr(7, 32'h12345678, 4'h0);
    pre(); nops(T_RP);
    act(2);
    wr(7, 32'hCAFEF00D, 4'h0);
    check_eq("req024_err", 32'(err), 32'(CHK));
    nop(); rd(7); nops(CAS_LAT + 1);
    check_eq("req024_q", last_q, CHK ? 32'h12345678 : 32'hCAFEF00D);

    // Reset with a read in flight, then READ while idle
    rd(7); nops(2);
    do_reset();
    nops(CAS_LAT + 2);
    rd(7); nops(CAS_LAT + 1);
    act(2); nop(); last_q = 32'h0;
    rd(7); nops(CAS_LAT + 1);
    check_eq("req025_q", last_q, CHK ? 32'h12345678 : 32'hCAFEF00D);

    // Fill rows 0..3 so every random read has a known expected word
    for (int row = 0; row < 4; row++) begin
      pre(); nops(T_RP);
      act(row); nops(T_RCD);
      for (int c = 0; c < (1 << COL_BITS); c++) wr(c, $urandom, 4'h0);
    end
    pre(); nops(T_RP);

    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r == 0)       do_reset();
      else if (r < 8)   nop();
      else if (r < 20)  act($urandom_range(0, 3));
      else if (r < 28)  pre();
      else if (r < 60)  rd($urandom_range(0, (1 << COL_BITS) - 1));
      else if (r < 88)  wr($urandom_range(0, (1 << COL_BITS) - 1), $urandom, 4'($urandom));
      else              issue(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 11'($urandom), $urandom);
    end

    nops(CAS_LAT + 2);
    check_eq("drain", 32'(rdq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
